adc_wave_meas: RTL and testbench
================================

Name: adc_wave_meas

Overview:
- Capture-side counterpart of the DAC waveform generator path.
- Clocks an external 8-bit ADC and samples its output.
- On request, measures the waveform's maximum, minimum and period, using hysteretic mid-level crossing detection.
- Results feed the display/readback logic and the loopback self-test of the generated waveform.

Parameters:
- CNT_W, 24: width of the period and timeout counters.
- NUM_PER_LOG2, 2: log2 of the number of periods averaged (default 4 periods).
- HYST, 8: hysteresis half-width, in LSB, around the threshold.
- TIMEOUT, 5_000_000: sys_clk cycles from arming before the measurement is abandoned.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- adc_data  in  8  ADC output code, unsigned.
- start  in  1  single-cycle measurement request.
- adc_clk  out  1  ADC sample clock, equal to ~sys_clk.
- meas_busy  out  1  high while a measurement is in progress.
- meas_done  out  1  one-cycle pulse when results are updated.
- timeout_flag  out  1  set if the last measurement timed out.
- wave_max  out  8  maximum code seen in the last measurement.
- wave_min  out  8  minimum code seen in the last measurement.
- period_cnt  out  CNT_W  averaged period in sys_clk cycles.

Behaviour:
- Interface: one clock (sys_clk); reset is asynchronous and active-high (rst).
- Reset values: meas_busy=0, meas_done=0, timeout_flag=0, wave_max=0, wave_min=0, period_cnt=0, FSM=IDLE, internal threshold=128, comparator state=low.
- Sampling:
  - adc_data is registered on the sys_clk rising edge into adc_s.
  - All logic below uses adc_s, giving 1 cycle input latency.
- Threshold:
  - thr = 128 until the first non-timeout measurement completes.
  - After that, thr = (wave_max + wave_min) >> 1, computed 9-bit, updated in DONE.
- Hysteretic comparator (active in ARM and MEAS only):
  - hi_lvl = min(thr+HYST, 255); lo_lvl = max(thr-HYST, 0).
  - State low -> high when adc_s >= hi_lvl; that cycle is a rising event.
  - State high -> low when adc_s <= lo_lvl.
  - Entering ARM forces state low if adc_s < thr, otherwise high, so a waveform already above threshold does not generate a false event.
- FSM:
  - IDLE:
    - meas_busy=0.
    - start=1 -> ARM; clear run_max=0, run_min=255, timer=0, edge_cnt=0, sum=0.
  - ARM:
    - meas_busy=1; run_max/run_min track adc_s.
    - Rising event -> MEAS with sum=0.
  - MEAS:
    - sum increments every cycle, saturating at all-ones.
    - Each rising event increments edge_cnt.
    - When edge_cnt reaches 2^NUM_PER_LOG2 -> DONE.
    - The cycle of the final event counts: sum = cycles from the first event to the last event.
  - Timeout: timer increments in ARM and MEAS. When timer == TIMEOUT-1 in either state -> DONE with timeout.
  - DONE (1 cycle):
    - wave_max <= run_max, wave_min <= run_min.
    - Normal completion: period_cnt <= sum >> NUM_PER_LOG2, timeout_flag <= 0, thr updated.
    - Timeout: period_cnt <= 0, timeout_flag <= 1, thr unchanged.
    - meas_done=1 in this cycle only; meas_busy=0; next state IDLE.
- start while meas_busy=1 or in DONE is ignored; no queuing.
- Simultaneous rising event and timeout in the same cycle: timeout wins.
- Outputs hold their values between measurements.
- rst asserted mid-measurement: immediate return to reset values; thr reverts to 128.
- adc_clk is purely combinational, with no gating, and toggles during reset.

Test Plan:
- Square wave 0/255, period 100 cycles, start pulse -> meas_done after about 5 periods; period_cnt=100, wave_max=255, wave_min=0, timeout_flag=0.
- Triangle 40..200, period 64 cycles, second start -> wave_max=200, wave_min=40, period_cnt=64; next thr=120, checked via crossings at 128/112.
- Constant adc_data=128, TIMEOUT=1000 -> meas_done exactly 1000 cycles after ARM entry; timeout_flag=1, period_cnt=0, wave_max=wave_min=128.
- Square wave 0/255 with ±4 LSB noise injected near each transition, HYST=8 -> no extra events; period_cnt equals the clean period.
- start pulses during MEAS -> ignored, single meas_done; start in the cycle after meas_done -> new measurement accepted.
- rst pulse mid-MEAS -> all outputs 0, meas_busy=0 asynchronously; next start uses thr=128 and yields a correct result.

Source files
------------

// File: rtl/adc_wave_meas_if.sv
// Bus between the ADC capture block and its consumer: ADC data/clock,
// the measurement request, and the measurement results.
interface adc_wave_meas_if #(
    parameter int unsigned CNT_W = 24
) ();
    logic [7:0]       adc_data;
    logic             start;
    logic             adc_clk;
    logic             meas_busy;
    logic             meas_done;
    logic             timeout_flag;
    logic [7:0]       wave_max;
    logic [7:0]       wave_min;
    logic [CNT_W-1:0] period_cnt;

    modport master (
        output adc_data, start,
        input  adc_clk, meas_busy, meas_done, timeout_flag,
               wave_max, wave_min, period_cnt
    );

    modport slave (
        input  adc_data, start,
        output adc_clk, meas_busy, meas_done, timeout_flag,
               wave_max, wave_min, period_cnt
    );
endinterface

// File: rtl/adc_wave_meas.sv
// Samples an 8-bit ADC and measures max, min and averaged period of the
// waveform using a hysteretic mid-level crossing detector.
module adc_wave_meas #(
    parameter int unsigned CNT_W        = 24,
    parameter int unsigned NUM_PER_LOG2 = 2,
    parameter int unsigned HYST         = 8,
    parameter int unsigned TIMEOUT      = 5_000_000
) (
    input  logic           sys_clk,
    input  logic           rst,
    adc_wave_meas_if.slave bus
);
    localparam int unsigned EDGE_W = NUM_PER_LOG2 + 1;
    localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'((1 << NUM_PER_LOG2) - 1);
    localparam logic [CNT_W-1:0]  TIMER_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [7:0]        HYST8      = 8'(HYST);
    localparam logic [7:0]        HI_LIM     = 8'(255 - HYST);
    localparam logic [7:0]        THR_RST    = 8'd128;

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_e;

    state_e state_q, state_d;

    logic [7:0]        adc_s_q;
    logic [7:0]        thr_q, thr_d;
    logic              cmp_q, cmp_d;
    logic [7:0]        run_max_q, run_max_d;
    logic [7:0]        run_min_q, run_min_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [CNT_W-1:0]  sum_q, sum_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tflag_q, tflag_d;
    logic [7:0]        wmax_q, wmax_d;
    logic [7:0]        wmin_q, wmin_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [8:0]        mid_sum;

    logic [7:0] hi_lvl, lo_lvl;
    logic       active, rise, fall, tmo;

    // Comparator levels, clamped to the code range
    always_comb begin
        hi_lvl = (thr_q > HI_LIM) ? 8'd255 : thr_q + HYST8;
        lo_lvl = (thr_q < HYST8)  ? 8'd0   : thr_q - HYST8;
        active = (state_q == ARM) || (state_q == MEAS);
        rise   = active && !cmp_q && (adc_s_q >= hi_lvl);
        fall   = active &&  cmp_q && (adc_s_q <= lo_lvl);
        tmo    = active && (timer_q == TIMER_LAST);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Timeout takes priority over a coincident rising event
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = ARM;
            ARM:     if (tmo) state_d = DONE;
                     else if (rise) state_d = MEAS;
            MEAS:    if (tmo) state_d = DONE;
                     else if (rise && (edge_q == EDGE_LAST)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        thr_d     = thr_q;
        cmp_d     = cmp_q;
        run_max_d = run_max_q;
        run_min_d = run_min_q;
        timer_d   = timer_q;
        edge_d    = edge_q;
        sum_d     = sum_q;
        tflag_d   = tflag_q;
        wmax_d    = wmax_q;
        wmin_d    = wmin_q;
        period_d  = period_q;
        mid_sum   = '0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    run_max_d = '0;
                    run_min_d = '1;
                    timer_d   = '0;
                    edge_d    = '0;
                    sum_d     = '0;
                    // Start on the side the waveform is already on
                    cmp_d     = (adc_s_q >= thr_q);
                end
            end
            ARM, MEAS: begin
                timer_d = timer_q + CNT_W'(1);
                if (adc_s_q > run_max_q) run_max_d = adc_s_q;
                if (adc_s_q < run_min_q) run_min_d = adc_s_q;
                if (rise)      cmp_d = 1'b1;
                else if (fall) cmp_d = 1'b0;
                if (state_q == MEAS) begin
                    sum_d = (sum_q == '1) ? sum_q : sum_q + CNT_W'(1);
                    if (rise) edge_d = edge_q + EDGE_W'(1);
                end else begin
                    sum_d = '0;
                end
            end
            default: ;
        endcase

        // Results load on DONE entry so they are valid alongside meas_done
        if (state_d == DONE) begin
            wmax_d = run_max_d;
            wmin_d = run_min_d;
            if (tmo) begin
                period_d = '0;
                tflag_d  = 1'b1;
            end else begin
                period_d = sum_d >> NUM_PER_LOG2;
                tflag_d  = 1'b0;
                mid_sum  = 9'(run_max_d) + 9'(run_min_d);
                thr_d    = 8'(mid_sum >> 1);
            end
        end

        busy_d = (state_d == ARM) || (state_d == MEAS);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            adc_s_q   <= '0;
            thr_q     <= THR_RST;
            cmp_q     <= 1'b0;
            run_max_q <= '0;
            run_min_q <= '1;
            timer_q   <= '0;
            edge_q    <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            tflag_q   <= 1'b0;
            wmax_q    <= '0;
            wmin_q    <= '0;
            period_q  <= '0;
        end else begin
            adc_s_q   <= bus.adc_data;
            thr_q     <= thr_d;
            cmp_q     <= cmp_d;
            run_max_q <= run_max_d;
            run_min_q <= run_min_d;
            timer_q   <= timer_d;
            edge_q    <= edge_d;
            sum_q     <= sum_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tflag_q   <= tflag_d;
            wmax_q    <= wmax_d;
            wmin_q    <= wmin_d;
            period_q  <= period_d;
        end
    end

    assign bus.adc_clk      = ~sys_clk;
    assign bus.meas_busy    = busy_q;
    assign bus.meas_done    = done_q;
    assign bus.timeout_flag = tflag_q;
    assign bus.wave_max     = wmax_q;
    assign bus.wave_min     = wmin_q;
    assign bus.period_cnt   = period_q;
endmodule

// File: tb/tb_adc_wave_meas.sv
// Directed bench for adc_wave_meas: square, triangle, threshold update,
// timeout, start handling, noise rejection and mid-measurement reset.
`timescale 1ns/1ps
module tb_adc_wave_meas;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned TMO   = 1000;

    logic sys_clk = 1'b0;
    logic rst;

    adc_wave_meas_if #(.CNT_W(CNT_W)) bus ();

    adc_wave_meas #(
        .CNT_W(CNT_W), .NUM_PER_LOG2(2), .HYST(8), .TIMEOUT(TMO)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int t     = 0;
    int mode  = 0;
    int lo_v  = 0;
    int hi_v  = 255;
    int per   = 100;
    int nz_r [5] = '{124, 130, 126, 131, 123};
    int nz_f [5] = '{130, 124, 131, 126, 123};

    // mode 0: square lo/hi, 1: triangle 40..200, 2: constant 128, 3: noisy 0/255 square
    function automatic logic [7:0] wave(input int tt);
        int ph;
        ph = tt % per;
        case (mode)
            0: return (ph < per / 2) ? 8'(lo_v) : 8'(hi_v);
            1: return (ph < per / 2) ? 8'(40 + 5 * ph) : 8'(200 - 5 * (ph - per / 2));
            2: return 8'(128);
            default: begin
                if (ph < 45)      return 8'(0);
                else if (ph < 50) return 8'(nz_r[ph - 45]);
                else if (ph < 95) return 8'(255);
                else              return 8'(nz_f[ph - 95]);
            end
        endcase
    endfunction

    task automatic cycle();
        @(posedge sys_clk);
        #1;
        bus.adc_data = wave(t);
        t++;
    endtask

    task automatic set_wave(input int m, input int lo, input int hi, input int p);
        mode = m; lo_v = lo; hi_v = hi; per = p; t = 0;
        bus.adc_data = wave(t);
        t++;
    endtask

    // Bounded wait for meas_done; s1/s2 are cycles at which extra start pulses are given
    task automatic wait_done(input int s1, input int s2, output int lat, output int arm_at);
        lat = -1; arm_at = -1;
        for (int i = 0; i < 1100; i++) begin
            cycle();
            bus.start = (i == s1) || (i == s2);
            if (arm_at < 0 && bus.meas_busy === 1'b1) arm_at = i;
            if (bus.meas_done === 1'b1) begin
                lat = i;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.start = 1'b0; bus.adc_data = 8'd0;
        repeat (3) cycle();
        total++; if (bus.meas_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.meas_busy); end
        total++; if (bus.meas_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.meas_done); end
        total++; if (bus.timeout_flag !== 1'b0) begin bad++; $display("FAIL rst_tflag got=%b exp=0", bus.timeout_flag); end
        total++; if (bus.wave_max !== 8'd0) begin bad++; $display("FAIL rst_max got=%0d exp=0", bus.wave_max); end
        total++; if (bus.wave_min !== 8'd0) begin bad++; $display("FAIL rst_min got=%0d exp=0", bus.wave_min); end
        total++; if (bus.period_cnt !== 24'd0) begin bad++; $display("FAIL rst_period got=%0d exp=0", bus.period_cnt); end
        total++; if (bus.adc_clk !== 1'b0) begin bad++; $display("FAIL adc_clk_hi got=%b exp=0", bus.adc_clk); end
        #5;
        total++; if (bus.adc_clk !== 1'b1) begin bad++; $display("FAIL adc_clk_lo got=%b exp=1", bus.adc_clk); end
        cycle();
        rst = 1'b0;
        repeat (2) cycle();
    endtask

    task automatic test_square();
        int lat, arm;
        set_wave(0, 0, 255, 100);
        bus.start = 1'b1;
        wait_done(-1, -1, lat, arm);
        total++; if (lat < 400 || lat > 510) begin bad++; $display("FAIL sq_latency got=%0d exp=400..510", lat); end
        total++; if (arm !== 0) begin bad++; $display("FAIL sq_arm got=%0d exp=0", arm); end
        cycle();
        total++; if (bus.meas_done !== 1'b0) begin bad++; $display("FAIL sq_done_pulse got=%b exp=0", bus.meas_done); end
        total++; if (bus.period_cnt !== 24'd100) begin bad++; $display("FAIL sq_period got=%0d exp=100", bus.period_cnt); end
        total++; if (bus.wave_max !== 8'd255) begin bad++; $display("FAIL sq_max got=%0d exp=255", bus.wave_max); end
        total++; if (bus.wave_min !== 8'd0) begin bad++; $display("FAIL sq_min got=%0d exp=0", bus.wave_min); end
        total++; if (bus.timeout_flag !== 1'b0) begin bad++; $display("FAIL sq_tflag got=%b exp=0", bus.timeout_flag); end
        total++; if (bus.meas_busy !== 1'b0) begin bad++; $display("FAIL sq_busy got=%b exp=0", bus.meas_busy); end
    endtask

    task automatic test_triangle();
        int lat, arm;
        set_wave(1, 40, 200, 64);
        bus.start = 1'b1;
        wait_done(-1, -1, lat, arm);
        total++; if (lat < 0) begin bad++; $display("FAIL tri_done got=none exp=meas_done"); end
        cycle();
        total++; if (bus.period_cnt !== 24'd64) begin bad++; $display("FAIL tri_period got=%0d exp=64", bus.period_cnt); end
        total++; if (bus.wave_max !== 8'd200) begin bad++; $display("FAIL tri_max got=%0d exp=200", bus.wave_max); end
        total++; if (bus.wave_min !== 8'd40) begin bad++; $display("FAIL tri_min got=%0d exp=40", bus.wave_min); end
    endtask

    // Threshold is now 120: levels 128/112 must just trip the comparator
    task automatic test_thr_update();
        int lat, arm;
        set_wave(0, 112, 128, 50);
        bus.start = 1'b1;
        wait_done(-1, -1, lat, arm);
        cycle();
        total++; if (bus.timeout_flag !== 1'b0) begin bad++; $display("FAIL thr_tflag got=%b exp=0", bus.timeout_flag); end
        total++; if (bus.period_cnt !== 24'd50) begin bad++; $display("FAIL thr_period got=%0d exp=50", bus.period_cnt); end
        total++; if (bus.wave_max !== 8'd128) begin bad++; $display("FAIL thr_max got=%0d exp=128", bus.wave_max); end
        total++; if (bus.wave_min !== 8'd112) begin bad++; $display("FAIL thr_min got=%0d exp=112", bus.wave_min); end
    endtask

    task automatic test_timeout();
        int lat, arm;
        set_wave(2, 128, 128, 10);
        bus.start = 1'b1;
        wait_done(-1, -1, lat, arm);
        total++; if (lat - arm !== 1000) begin bad++; $display("FAIL tmo_latency got=%0d exp=1000", lat - arm); end
        cycle();
        total++; if (bus.timeout_flag !== 1'b1) begin bad++; $display("FAIL tmo_tflag got=%b exp=1", bus.timeout_flag); end
        total++; if (bus.period_cnt !== 24'd0) begin bad++; $display("FAIL tmo_period got=%0d exp=0", bus.period_cnt); end
        total++; if (bus.wave_max !== 8'd128) begin bad++; $display("FAIL tmo_max got=%0d exp=128", bus.wave_max); end
        total++; if (bus.wave_min !== 8'd128) begin bad++; $display("FAIL tmo_min got=%0d exp=128", bus.wave_min); end
    endtask

    task automatic test_start_ignored();
        int lat, arm, extra;
        set_wave(0, 0, 255, 100);
        bus.start = 1'b1;
        wait_done(150, 300, lat, arm);
        total++; if (lat < 400 || lat > 510) begin bad++; $display("FAIL ign_latency got=%0d exp=400..510", lat); end
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        total++; if (bus.meas_busy !== 1'b0) begin bad++; $display("FAIL ign_done_start got=%b exp=0", bus.meas_busy); end
        total++; if (bus.period_cnt !== 24'd100) begin bad++; $display("FAIL ign_period got=%0d exp=100", bus.period_cnt); end
        total++; if (bus.timeout_flag !== 1'b0) begin bad++; $display("FAIL ign_tflag got=%b exp=0", bus.timeout_flag); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (bus.meas_done === 1'b1 || bus.meas_busy === 1'b1) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ign_extra got=%0d exp=0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat, arm;
        set_wave(0, 0, 255, 100);
        bus.start = 1'b1;
        wait_done(-1, -1, lat, arm);
        cycle();
        total++; if (bus.meas_busy !== 1'b0 || bus.meas_done !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b%b exp=00", bus.meas_busy, bus.meas_done); end
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        total++; if (bus.meas_busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got=%b exp=1", bus.meas_busy); end
        wait_done(-1, -1, lat, arm);
        total++; if (lat < 0) begin bad++; $display("FAIL b2b_done got=none exp=meas_done"); end
        cycle();
        total++; if (bus.period_cnt !== 24'd100) begin bad++; $display("FAIL b2b_period got=%0d exp=100", bus.period_cnt); end
    endtask

    task automatic test_noise();
        int lat, arm;
        set_wave(3, 0, 255, 100);
        bus.start = 1'b1;
        wait_done(-1, -1, lat, arm);
        total++; if (lat < 400 || lat > 510) begin bad++; $display("FAIL nz_latency got=%0d exp=400..510", lat); end
        cycle();
        total++; if (bus.period_cnt !== 24'd100) begin bad++; $display("FAIL nz_period got=%0d exp=100", bus.period_cnt); end
        total++; if (bus.wave_max !== 8'd255) begin bad++; $display("FAIL nz_max got=%0d exp=255", bus.wave_max); end
        total++; if (bus.wave_min !== 8'd0) begin bad++; $display("FAIL nz_min got=%0d exp=0", bus.wave_min); end
    endtask

    task automatic test_rst_mid();
        int lat, arm;
        set_wave(0, 0, 255, 100);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        repeat (199) cycle();
        total++; if (bus.meas_busy !== 1'b1) begin bad++; $display("FAIL rm_busy_pre got=%b exp=1", bus.meas_busy); end
        #2 rst = 1'b1;
        #1;
        total++; if (bus.meas_busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", bus.meas_busy); end
        total++; if (bus.period_cnt !== 24'd0) begin bad++; $display("FAIL rm_period got=%0d exp=0", bus.period_cnt); end
        total++; if (bus.wave_max !== 8'd0 || bus.wave_min !== 8'd0) begin bad++; $display("FAIL rm_maxmin got=%0d/%0d exp=0/0", bus.wave_max, bus.wave_min); end
        total++; if (bus.timeout_flag !== 1'b0 || bus.meas_done !== 1'b0) begin bad++; $display("FAIL rm_flags got=%b%b exp=00", bus.timeout_flag, bus.meas_done); end
        repeat (2) cycle();
        rst = 1'b0;
        cycle();
        // Levels 120/136 only trip the comparator with threshold 128
        set_wave(0, 120, 136, 40);
        bus.start = 1'b1;
        wait_done(-1, -1, lat, arm);
        cycle();
        total++; if (bus.timeout_flag !== 1'b0) begin bad++; $display("FAIL rm_tflag got=%b exp=0", bus.timeout_flag); end
        total++; if (bus.period_cnt !== 24'd40) begin bad++; $display("FAIL rm_period2 got=%0d exp=40", bus.period_cnt); end
        total++; if (bus.wave_max !== 8'd136) begin bad++; $display("FAIL rm_max got=%0d exp=136", bus.wave_max); end
        total++; if (bus.wave_min !== 8'd120) begin bad++; $display("FAIL rm_min got=%0d exp=120", bus.wave_min); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_triangle();
        test_thr_update();
        test_timeout();
        test_start_ignored();
        test_back_to_back();
        test_noise();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
